// File: rtl/conv_fprop3_acc_pkg.sv
// Shared definitions for the conv_fprop3 accumulate stage: FSM encoding,
// shift-field width and the saturation bounds of the output word.
package conv_fprop3_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } acc_state_e;

  localparam int SHIFT_WIDTH = 5;

  function automatic int satMax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int satMin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/conv_fprop3_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clip of the
// accumulated pixel into the signed output width.
module conv_fprop3_round_sat
  import conv_fprop3_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 10
) (
  input  logic signed [ACC_WIDTH-1:0]   acc_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output logic signed [OUT_WIDTH-1:0]   data_o,
  output logic                          sat_o
);

  // One guard bit so adding the rounding constant never wraps.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MaxV = RW'(satMax(OUT_WIDTH));
  localparam logic signed [RW-1:0] MinV = RW'(satMin(OUT_WIDTH));

  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] shifted;

  always_comb begin
    rnd = '0;
    if (shift_i != '0) begin
      rnd = RW'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    sum     = {acc_i[ACC_WIDTH-1], acc_i} + rnd;
    shifted = sum >>> shift_i;
    // Shifting past the whole accumulator leaves only the sign.
    if (int'(shift_i) >= ACC_WIDTH) begin
      shifted = acc_i[ACC_WIDTH-1] ? '1 : '0;
    end
    sat_o  = 1'b0;
    data_o = shifted[OUT_WIDTH-1:0];
    if (shifted > MaxV) begin
      data_o = MaxV[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (shifted < MinV) begin
      data_o = MinV[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/conv_fprop3_acc_stage.sv
// Accumulates klen signed products plus a bias into one pixel, then rounds,
// shifts and saturates it behind a valid/ready handshake on both sides.
module conv_fprop3_acc_stage
  import conv_fprop3_acc_pkg::*;
#(
  parameter int PROD_WIDTH = 10,
  parameter int BIAS_WIDTH = 10,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 10,
  parameter int KLEN_WIDTH = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic        [KLEN_WIDTH-1:0] cfg_klen,
  input  logic       [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic signed [PROD_WIDTH-1:0] prod_tdata,
  input  logic                         prod_tvalid,
  output logic                         prod_tready,
  output logic signed  [OUT_WIDTH-1:0] out_tdata,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         sat_flag,
  output logic                         busy
);

  acc_state_e state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [KLEN_WIDTH-1:0]       cnt_q;
  logic [KLEN_WIDTH-1:0]       klen_q;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic signed [OUT_WIDTH-1:0] outData_q;
  logic                        satFlag_q;
  logic                        outValid_q;

  logic                        beat;
  logic [KLEN_WIDTH-1:0]       klenFirst;
  logic signed [OUT_WIDTH-1:0] rsData;
  logic                        rsSat;

  assign beat      = prod_tvalid & prod_tready;
  // A zero kernel length would never terminate, so it is treated as one.
  assign klenFirst = (cfg_klen == '0) ? KLEN_WIDTH'(1) : cfg_klen;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (beat) state_d = (klenFirst == KLEN_WIDTH'(1)) ? FINAL : ACC;
      ACC:   if (beat && cnt_q == klen_q - KLEN_WIDTH'(1)) state_d = FINAL;
      FINAL: state_d = OUT;
      OUT:   if (out_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_tready = (state_q == IDLE) || (state_q == ACC);
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      klen_q     <= '0;
      shift_q    <= '0;
      outData_q  <= '0;
      satFlag_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (beat) begin
          klen_q  <= klenFirst;
          shift_q <= cfg_shift;
          acc_q   <= ACC_WIDTH'(bias) + ACC_WIDTH'(prod_tdata);
          cnt_q   <= KLEN_WIDTH'(1);
        end
        ACC: if (beat) begin
          acc_q <= acc_q + ACC_WIDTH'(prod_tdata);
          cnt_q <= cnt_q + KLEN_WIDTH'(1);
        end
        FINAL: begin
          outData_q  <= rsData;
          satFlag_q  <= rsSat;
          outValid_q <= 1'b1;
        end
        OUT: if (out_tready) outValid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  conv_fprop3_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_round_sat (
    .acc_i  (acc_q),
    .shift_i(shift_q),
    .data_o (rsData),
    .sat_o  (rsSat)
  );

  assign out_tdata  = outData_q;
  assign out_tvalid = outValid_q;
  assign sat_flag   = satFlag_q;

endmodule

// File: tb/tb_conv_fprop3_acc_stage.sv
// Directed bench for conv_fprop3_acc_stage; inputs driven and outputs
// sampled on the falling edge, expected values worked out by hand.
module tb_conv_fprop3_acc_stage;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [7:0]        cfg_klen;
  logic [4:0]        cfg_shift;
  logic signed [9:0] bias;
  logic signed [9:0] prod_tdata;
  logic              prod_tvalid;
  logic              prod_tready;
  logic signed [9:0] out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              sat_flag;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  always #5 ap_clk = ~ap_clk;

  conv_fprop3_acc_stage dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .cfg_klen   (cfg_klen),
    .cfg_shift  (cfg_shift),
    .bias       (bias),
    .prod_tdata (prod_tdata),
    .prod_tvalid(prod_tvalid),
    .prod_tready(prod_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checkCount++;
    if (obs == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Presents one product and returns on the falling edge after it was taken.
  task automatic sendBeat(input int p);
    int n = 0;
    prod_tvalid = 1'b1;
    prod_tdata  = 10'(p);
    while (!prod_tready && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    if (!prod_tready) checkOutput("beatTimeout", 0, 1);
    @(negedge ap_clk);
    prod_tvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int klen, input int shift, input int biasV,
                               input int n, input int prods[4]);
    cfg_klen  = 8'(klen);
    cfg_shift = 5'(shift);
    bias      = 10'(biasV);
    for (int i = 0; i < n; i++) sendBeat(prods[i]);
  endtask

  task automatic waitResult(input string tag, input int expData, input int expSat);
    int n = 0;
    while (!out_tvalid && n < 10) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput({tag, "_valid"}, longint'(out_tvalid), 1);
    checkOutput({tag, "_data"}, longint'(out_tdata), expData);
    checkOutput({tag, "_sat"}, longint'(sat_flag), expSat);
    out_tready = 1'b1;
    @(negedge ap_clk);
    out_tready = 1'b0;
    checkOutput({tag, "_consumed"}, longint'(out_tvalid), 0);
  endtask

  initial begin
    ap_rst      = 1'b1;
    cfg_klen    = '0;
    cfg_shift   = '0;
    bias        = '0;
    prod_tdata  = '0;
    prod_tvalid = 1'b0;
    out_tready  = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;

    checkOutput("rst_tvalid", longint'(out_tvalid), 0);
    checkOutput("rst_tdata", longint'(out_tdata), 0);
    checkOutput("rst_sat", longint'(sat_flag), 0);
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_tready", longint'(prod_tready), 1);

    // Basic pixel: 3+10+20-5+7=35, (35+2)>>>2=9, valid two cycles after last beat
    applyStimulus(4, 2, 3, 4, '{10, 20, -5, 7});
    checkOutput("basic_lat1", longint'(out_tvalid), 0);
    checkOutput("basic_busy", longint'(busy), 1);
    @(negedge ap_clk);
    checkOutput("basic_lat2", longint'(out_tvalid), 1);
    waitResult("basic", 9, 0);
    checkOutput("basic_idle", longint'(busy), 0);

    applyStimulus(2, 0, 0, 2, '{511, 511, 0, 0});
    waitResult("satHi", 511, 1);
    applyStimulus(2, 0, 0, 2, '{-512, -512, 0, 0});
    waitResult("satLo", -512, 1);

    // Backpressure: 5+100=105 held while downstream stalls
    applyStimulus(1, 0, 5, 1, '{100, 0, 0, 0});
    @(negedge ap_clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", longint'(out_tvalid), 1);
      checkOutput("bp_data", longint'(out_tdata), 105);
      checkOutput("bp_sat", longint'(sat_flag), 0);
      checkOutput("bp_tready", longint'(prod_tready), 0);
      @(negedge ap_clk);
    end
    waitResult("bp", 105, 0);
    checkOutput("bp_nextReady", longint'(prod_tready), 1);
    applyStimulus(1, 0, 0, 1, '{-3, 0, 0, 0});
    waitResult("bpNext", -3, 0);

    // klen=0 acts as 1: (-7+1)>>>1=-3
    applyStimulus(0, 1, 0, 1, '{-7, 0, 0, 0});
    waitResult("klen0", -3, 0);
    applyStimulus(1, 1, 0, 1, '{-7, 0, 0, 0});
    waitResult("klen1", -3, 0);

    // Bubbles and a config change after the first beat: 1+4+5+6=16
    cfg_klen  = 8'd3;
    cfg_shift = 5'd0;
    bias      = 10'sd1;
    sendBeat(4);
    cfg_klen  = 8'd9;
    bias      = 10'sd100;
    repeat (2) @(negedge ap_clk);
    checkOutput("gap_busy", longint'(busy), 1);
    sendBeat(5);
    @(negedge ap_clk);
    checkOutput("gap_noValid", longint'(out_tvalid), 0);
    sendBeat(6);
    waitResult("gap", 16, 0);

    // Reset after 2 of 4 beats, then a fresh pixel: 2+3+4=9, (9+1)>>>1=5
    applyStimulus(4, 0, 0, 2, '{100, 100, 0, 0});
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    checkOutput("midRst_busy", longint'(busy), 0);
    checkOutput("midRst_tvalid", longint'(out_tvalid), 0);
    checkOutput("midRst_tdata", longint'(out_tdata), 0);
    checkOutput("midRst_tready", longint'(prod_tready), 1);
    applyStimulus(2, 1, 2, 2, '{3, 4, 0, 0});
    waitResult("postRst", 5, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
